// File: rtl/axi_uart_lite_rx_pkg.sv
// uart_lite_pkg: shared constants for the UART-Lite RX slave.
//   - register offsets (decoded on addr[3:2])
//   - STAT bit positions and CTRL FIFO-reset bit
//   - RX deserializer FSM states
package uart_lite_pkg;

  localparam logic [3:0] ADDR_RX   = 4'h0;
  localparam logic [3:0] ADDR_TX   = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;
  localparam logic [3:0] ADDR_CTRL = 4'hC;

  localparam int STAT_RX_VALID  = 0;
  localparam int STAT_RX_FULL   = 1;
  localparam int STAT_TX_EMPTY  = 2;
  localparam int STAT_OVERRUN   = 5;
  localparam int STAT_FRAME_ERR = 6;

  localparam int CTRL_RST_RX = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Register select from a byte address: only addr[3:2] matters.
  function automatic logic [1:0] reg_sel(input logic [3:0] offs);
    return offs[3:2];
  endfunction

endpackage

// File: rtl/axi_uart_lite_rx_core.sv
// uart_rx_core: 8N1 serial deserializer.
//   clk, rst      : system clock, async active-high reset
//   rxd           : raw serial input (idle high, asynchronous)
//   data          : received byte, meaningful while valid pulses
//   valid         : one-cycle strobe, good stop bit seen
//   frame_err     : one-cycle strobe, stop bit sampled low
module uart_rx_core
  import uart_lite_pkg::*;
#(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);

  logic          sync1, sync2, prev;
  rx_state_t     state, next_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick, fall;

  assign tick = (cnt == '0);
  // Edge rather than level, so a line left low by a bad stop bit
  // does not immediately retrigger a new frame.
  assign fall = prev & ~sync2;
  assign data = shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    valid      = 1'b0;
    frame_err  = 1'b0;
    case (state)
      RX_IDLE:  if (fall) next_state = RX_START;
      RX_START: if (tick) next_state = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) next_state = RX_STOP;
      RX_STOP: begin
        if (tick) begin
          next_state = RX_IDLE;
          valid      = sync2;
          frame_err  = ~sync2;
        end
      end
      default:  next_state = RX_IDLE;
    endcase
  end

  // Baud counter, bit index and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          bit_idx <= '0;
          if (fall) cnt <= CNT_HALF;
        end
        RX_DATA: begin
          if (tick) begin
            cnt     <= CNT_FULL;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (tick) cnt <= CNT_FULL;
          else      cnt <= cnt - 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/axi_uart_lite_rx.sv
// axi_uart_lite_rx: AXI4-Lite slave, UART-Lite register map, RX only.
//   CLK, RST          : clock, async active-high reset
//   RXD               : serial input
//   S_AXI_AW*/W*/B*   : write path; only CTRL bit1 (FIFO clear) acts
//   S_AXI_AR*/R*      : read path; RX pops the FIFO, STAT clears stickies
// Parameters: CLK_PER_BIT (>=4), FIFO_DEPTH (power of two).
module axi_uart_lite_rx
  import uart_lite_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RXD,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferr;

  uart_rx_core #(.CLK_PER_BIT(CLK_PER_BIT)) u_core (
    .clk       (CLK),
    .rst       (RST),
    .rxd       (RXD),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  // FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  logic        ar_hs, aw_hs, pop, push, clr, stat_rd, ovr_set;
  logic        ovr, ferr;
  logic [1:0]  rsel, wsel;
  logic [7:0]  stat;

  assign rsel = S_AXI_ARADDR[3:2];
  assign wsel = S_AXI_AWADDR[3:2];

  // Ready lines are held low during reset, then follow the handshake rules
  assign S_AXI_ARREADY = ~S_AXI_RVALID & ~RST;
  assign aw_hs         = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~RST;
  assign S_AXI_AWREADY = aw_hs;
  assign S_AXI_WREADY  = aw_hs;
  assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

  assign S_AXI_RRESP = RESP_OKAY;
  assign S_AXI_BRESP = RESP_OKAY;

  assign pop     = ar_hs && rsel == reg_sel(ADDR_RX) && !empty;
  assign stat_rd = ar_hs && rsel == reg_sel(ADDR_STAT);
  assign clr     = aw_hs && wsel == reg_sel(ADDR_CTRL) && S_AXI_WDATA[CTRL_RST_RX];
  // A simultaneous pop frees a slot, so a full FIFO still accepts the byte
  assign push    = rx_valid && (!full || pop) && !clr;
  assign ovr_set = rx_valid && full && !pop && !clr;

  always_comb begin
    stat                 = '0;
    stat[STAT_RX_VALID]  = ~empty;
    stat[STAT_RX_FULL]   = full;
    stat[STAT_TX_EMPTY]  = 1'b1;
    stat[STAT_OVERRUN]   = ovr;
    stat[STAT_FRAME_ERR] = ferr;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[PW-1:0]] <= rx_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle as a STAT read survives
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (ovr_set)      ovr <= 1'b1;
      else if (stat_rd) ovr <= 1'b0;
      if (rx_ferr)      ferr <= 1'b1;
      else if (stat_rd) ferr <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
    end else begin
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        case (rsel)
          reg_sel(ADDR_RX):   S_AXI_RDATA <= empty ? 32'h0 : {24'h0, mem[rd_ptr[PW-1:0]]};
          reg_sel(ADDR_STAT): S_AXI_RDATA <= {24'h0, stat};
          default:            S_AXI_RDATA <= 32'h0;
        endcase
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)               S_AXI_BVALID <= 1'b0;
    else if (aw_hs)        S_AXI_BVALID <= 1'b1;
    else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
  end

  // Inputs with no function in an RX-only slave
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_AWADDR[31:4],
                    S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:4], S_AXI_ARADDR[1:0],
                    S_AXI_WDATA[31:2], S_AXI_WDATA[0]};

endmodule

// File: tb/tb_axi_uart_lite_rx.sv
module tb_axi_uart_lite_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  logic        CLK = 0, RST = 0, RXD = 1;
  logic [31:0] S_AXI_AWADDR = 0, S_AXI_WDATA = 0, S_AXI_ARADDR = 0;
  logic [2:0]  S_AXI_AWPROT = 0, S_AXI_ARPROT = 0;
  logic [3:0]  S_AXI_WSTRB = 4'hF;
  logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 1;
  logic        S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
  logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;

  axi_uart_lite_rx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 CLK = ~CLK;

  int total = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // One 8N1 frame, LSB first, bits changed on the falling clock edge
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge CLK); RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = stop;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold, output logic [31:0] d);
    int n;
    @(negedge CLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    n = 0;
    while (!S_AXI_ARREADY && n < 100) begin @(negedge CLK); n++; end
    if (n >= 100) chk("ar_timeout", 0, 1);
    @(negedge CLK);
    S_AXI_ARVALID = 0;
    chk("rvalid_latency", {31'h0, S_AXI_RVALID}, 1);
    d = S_AXI_RDATA;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("rdata_stable", S_AXI_RDATA, d);
      chk("arready_low", {31'h0, S_AXI_ARREADY}, 0);
    end
    S_AXI_RREADY = 1;
    @(negedge CLK);
    S_AXI_RREADY = 0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int n;
    @(negedge CLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    n = 0;
    while (!S_AXI_AWREADY && n < 100) begin @(negedge CLK); n++; end
    if (n >= 100) chk("aw_timeout", 0, 1);
    @(negedge CLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    chk("bvalid", {31'h0, S_AXI_BVALID}, 1);
    @(negedge CLK);
  endtask

  typedef enum int {OP_SEND, OP_READ, OP_WRITE} op_t;
  typedef struct {
    op_t         op;
    logic [31:0] addr;
    logic [31:0] data;   // byte to send or word to write
    logic        stop;
    logic [31:0] exp;    // expected RDATA for reads
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] rd;
  byte unsigned mq[$];
  logic        m_ovr, m_fe;

  function automatic logic [31:0] model_stat();
    logic [31:0] s = 32'h4;
    if (mq.size() != 0)     s[0] = 1;
    if (mq.size() == DEPTH) s[1] = 1;
    if (m_ovr)              s[5] = 1;
    if (m_fe)               s[6] = 1;
    return s;
  endfunction

  initial begin
    // reset
    RST = 1;
    repeat (3) @(negedge CLK);
    chk("rst_arready", {31'h0, S_AXI_ARREADY}, 0);
    chk("rst_awready", {31'h0, S_AXI_AWREADY}, 0);
    chk("rst_rvalid",  {31'h0, S_AXI_RVALID}, 0);
    chk("rst_bvalid",  {31'h0, S_AXI_BVALID}, 0);
    chk("rst_rdata",   S_AXI_RDATA, 0);
    RST = 0;
    @(negedge CLK);

    vecs = '{
      '{OP_READ,  32'h8, 0, 1, 32'h4},
      '{OP_READ,  32'h0, 0, 1, 32'h0},
      '{OP_SEND,  0, 32'hA5, 1, 0},
      '{OP_READ,  32'h8, 0, 1, 32'h5},
      '{OP_READ,  32'h0, 0, 1, 32'hA5},
      '{OP_READ,  32'h8, 0, 1, 32'h4},
      '{OP_SEND,  0, 32'h3C, 0, 0},
      '{OP_READ,  32'h8, 0, 1, 32'h44},
      '{OP_READ,  32'h8, 0, 1, 32'h4},
      '{OP_SEND,  0, 32'h11, 1, 0},
      '{OP_SEND,  0, 32'h22, 1, 0},
      '{OP_SEND,  0, 32'h33, 1, 0},
      '{OP_WRITE, 32'h4, 32'h41, 1, 0},
      '{OP_WRITE, 32'hC, 32'h1, 1, 0},
      '{OP_READ,  32'h8, 0, 1, 32'h5},
      '{OP_READ,  32'h4, 0, 1, 32'h0},
      '{OP_READ,  32'hC, 0, 1, 32'h0},
      '{OP_WRITE, 32'hC, 32'h2, 1, 0},
      '{OP_READ,  32'h8, 0, 1, 32'h4},
      '{OP_READ,  32'h0, 0, 1, 32'h0}
    };
    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_SEND:  send_byte(vecs[i].data[7:0], vecs[i].stop);
        OP_WRITE: axi_write(vecs[i].addr, vecs[i].data);
        default: begin
          axi_read(vecs[i].addr, 0, rd);
          chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end
      endcase
    end

    // 17 bytes into a 16-deep FIFO; full implies non-empty, so bit0 is set too
    for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1);
    axi_read(32'h8, 0, rd); chk("ovr_stat", rd, 32'h27);
    axi_read(32'h8, 0, rd); chk("ovr_stat_cleared", rd, 32'h07);
    for (int i = 0; i < 16; i++) begin
      axi_read(32'h0, 0, rd);
      chk($sformatf("pop%0d", i), rd, 32'(i));
    end
    axi_read(32'h8, 0, rd); chk("drained_stat", rd, 32'h4);

    // short low glitch: START rejects it silently
    @(negedge CLK); RXD = 0;
    repeat (CPB / 4) @(negedge CLK);
    RXD = 1;
    repeat (12 * CPB) @(negedge CLK);
    axi_read(32'h8, 0, rd); chk("glitch_stat", rd, 32'h4);

    // RREADY held low for 5 cycles on an RX read
    send_byte(8'h5A, 1'b1);
    axi_read(32'h0, 5, rd); chk("hold_rdata", rd, 32'h5A);

    // reset mid-frame and with a read response pending
    @(negedge CLK); RXD = 0;
    repeat (3 * CPB) @(negedge CLK);
    S_AXI_ARADDR = 32'h8; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    @(negedge CLK); S_AXI_ARVALID = 0;
    chk("pre_rst_rvalid", {31'h0, S_AXI_RVALID}, 1);
    RST = 1; RXD = 1;
    @(negedge CLK);
    chk("rst_withdraw_rvalid", {31'h0, S_AXI_RVALID}, 0);
    RST = 0;
    repeat (12 * CPB) @(negedge CLK);
    axi_read(32'h8, 0, rd); chk("midframe_rst_stat", rd, 32'h4);

    // randomized traffic against a queue model
    m_ovr = 0; m_fe = 0;
    for (int it = 0; it < 60; it++) begin
      int sel = $urandom_range(0, 9);
      if (sel < 5) begin
        logic [7:0] b  = 8'($urandom);
        logic       sb = ($urandom_range(0, 5) != 0);
        send_byte(b, sb);
        if (!sb)                 m_fe = 1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else                     m_ovr = 1;
      end else if (sel < 7) begin
        logic [31:0] e = (mq.size() != 0) ? 32'(mq.pop_front()) : 32'h0;
        axi_read(32'h0, $urandom_range(0, 2), rd);
        chk($sformatf("rnd%0d_rx", it), rd, e);
      end else if (sel < 9) begin
        logic [31:0] e = model_stat();
        axi_read(32'h8, 0, rd);
        chk($sformatf("rnd%0d_stat", it), rd, e);
        m_ovr = 0; m_fe = 0;
      end else begin
        logic [31:0] w = $urandom;
        axi_write(32'hC, w);
        if (w[1]) mq.delete();
      end
    end
    axi_read(32'h8, 0, rd); chk("rnd_final_stat", rd, model_stat());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
